ptm_feeder: RTL and testbench

PTM_FEEDER -- requirements
Module: ptm_feeder

---
 rtl/ptm_feeder.sv | 104 ++++++++++
 tb/tb_ptm_feeder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptm_feeder.sv
// Job loader that buffers a length-prefixed word stream into a 1024x10 memory and serves it to a matcher.
// Optional feature: define PTM_FEEDER_LEN_CHECK_EN to reject zero-length jobs with an err pulse.
module ptm_feeder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [9:0] in_data,
    output logic       in_ready,
    output logic       start,
    input  logic       en,
    input  logic [9:0] addr,
    output logic [9:0] data,
    input  logic       done,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, LEN, LOAD, RUN} state_t;

    state_t     state, state_nxt;
    logic [9:0] mem [1024];
    logic [9:0] len_q;
    logic [9:0] wptr;
    logic       xfer;
    logic       len_zero;
    logic       len_reject;
    logic       mem_we;
    logic [9:0] mem_waddr;

    // IDLE raises in_ready but only LEN and LOAD actually consume a word.
    assign xfer     = in_valid && in_ready && (state == LEN || state == LOAD);
    assign len_zero = (in_data == 10'd0);

`ifdef PTM_FEEDER_LEN_CHECK_EN
    assign len_reject = xfer && (state == LEN) && len_zero;
`else
    assign len_reject = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = LEN;
            LEN:  if (xfer && !len_reject) state_nxt = len_zero ? RUN : LOAD;
            LOAD: if (xfer && wptr == len_q) state_nxt = RUN;
            RUN:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state != RUN);
        busy     = (state != IDLE);
    end

    // Registered outputs and load pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            start <= 1'b0;
            len_q <= 10'd0;
            wptr  <= 10'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            start <= (state_nxt == RUN);
            if (state == LEN && xfer && !len_reject) begin
                len_q <= in_data;
                wptr  <= 10'd1;
            end else if (state == LOAD && xfer && wptr != len_q) begin
                // The final word leaves wptr at L, so L=1023 never wraps to 0.
                wptr <= wptr + 10'd1;
            end
        end
    end

`ifdef PTM_FEEDER_LEN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= len_reject;
    end
`else
    assign err = 1'b0;
`endif

    assign mem_we    = xfer && !len_reject && !rst;
    assign mem_waddr = (state == LEN) ? 10'd0 : wptr;

    // NOTE: the memory is deliberately not reset; contents persist across jobs and reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= in_data;
    end

    // Asynchronous read: a same-cycle write to addr is only visible after the edge.
    assign data = en ? mem[addr] : 10'd0;

endmodule

// File: tb/tb_ptm_feeder.sv
// Self-checking bench for ptm_feeder: a scoreboard of expected memory words filled as words are consumed
// and drained by reading the memory back through the matcher port while in RUN.
module tb_ptm_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [9:0] in_data;
    logic       in_ready;
    logic       start;
    logic       en;
    logic [9:0] addr;
    logic [9:0] data;
    logic       done;
    logic       busy;
    logic       err;

    ptm_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .start    (start),
        .en       (en),
        .addr     (addr),
        .data     (data),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

`ifdef PTM_FEEDER_LEN_CHECK_EN
    localparam bit CHECK_MODE = 1'b1;
`else
    localparam bit CHECK_MODE = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] a;
        logic [9:0] d;
    } exp_t;

    exp_t sb[$];
    int   job_q[$];
    int   total = 0;
    int   bad   = 0;
    int   job_cycles;
    int   job_errs;
    int   job_early;
    bit   job_timeout;

    // Present job_q word by word; record cycles used, err pulses, early start and timeout.
    task automatic drive_job(input bit throttle);
        int   idx;
        int   waddr;
        int   cyc;
        bit   cons;
        exp_t e;
        idx = 0; waddr = 0; cyc = 0;
        job_errs = 0; job_early = 0; job_timeout = 1'b0;
        while (idx < job_q.size() && cyc < 4000) begin
            @(negedge clk);
            if (err === 1'b1) job_errs++;
            if (start !== 1'b0) job_early++;
            in_valid = throttle ? ~cyc[0] : 1'b1;
            in_data  = 10'(job_q[idx]);
            cons = in_valid && in_ready && busy;
            @(posedge clk);
            if (cons) begin
                if (!(CHECK_MODE && waddr == 0 && job_q[idx] == 0)) begin
                    e.a = waddr[9:0];
                    e.d = 10'(job_q[idx]);
                    sb.push_back(e);
                    waddr++;
                end
                idx++;
            end
            cyc++;
        end
        @(negedge clk);
        if (err === 1'b1) job_errs++;
        in_valid = 1'b0;
        job_timeout = (idx < job_q.size());
        job_cycles  = cyc;
    endtask

    task automatic drain_sb(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            en   = 1'b1;
            addr = e.a;
            #1;
            total++;
            if (data !== e.d) begin
                bad++;
                $display("FAIL %s mem[%0d]: got %0d want %0d", tag, e.a, data, e.d);
            end
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic check_job(input string tag, input int want_cycles, input int want_errs);
        total++;
        if (job_timeout || job_cycles != want_cycles) begin
            bad++;
            $display("FAIL %s cycles: got %0d (timeout=%0d) want %0d", tag, job_cycles, job_timeout, want_cycles);
        end
        total++;
        if (job_errs != want_errs) begin
            bad++;
            $display("FAIL %s err pulses: got %0d want %0d", tag, job_errs, want_errs);
        end
        total++;
        if (job_early != 0) begin
            bad++;
            $display("FAIL %s start before final word: got %0d cycles want 0", tag, job_early);
        end
        total++;
        if ({start, busy, in_ready} !== 3'b110) begin
            bad++;
            $display("FAIL %s run outputs start/busy/in_ready: got %b want 110", tag, {start, busy, in_ready});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; en = 1'b0; addr = '0; done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({start, busy, err, in_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset outputs start/busy/err/in_ready: got %b want 0001", {start, busy, err, in_ready});
        end
        // done outside RUN must not wake the FSM
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL done_in_idle busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        job_q = '{3, 1, 0, 1};
        drive_job(1'b0);
        check_job("basic", 5, 0);
        // in_valid is ignored in RUN
        in_valid = 1'b1; in_data = 10'h3FF;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (start !== 1'b1) begin
            bad++;
            $display("FAIL run_ignores_valid start: got %b want 1", start);
        end
        en = 1'b1; addr = 10'd2; #1;
        total++;
        if (data !== 10'd0) begin bad++; $display("FAIL readback addr2: got %0d want 0", data); end
        @(negedge clk);
        en = 1'b0; addr = 10'd0; #1;
        total++;
        if (data !== 10'd0) begin bad++; $display("FAIL readback en0: got %0d want 0", data); end
        @(negedge clk);
        en = 1'b1; addr = 10'd0; #1;
        total++;
        if (data !== 10'd3) begin bad++; $display("FAIL readback addr0: got %0d want 3", data); end
        drain_sb("basic");
    endtask

    task automatic test_back_to_back();
        pulse_done();
        total++;
        if ({start, busy, in_ready} !== 3'b001) begin
            bad++;
            $display("FAIL done start/busy/in_ready: got %b want 001", {start, busy, in_ready});
        end
        job_q = '{2, 10'h155, 10'h2AA};
        drive_job(1'b0);
        check_job("second_job", 4, 0);
        drain_sb("second_job");
        pulse_done();
    endtask

    task automatic test_throttle();
        job_q = '{2, 7, 9};
        drive_job(1'b1);
        check_job("throttle", 7, 0);
        total++;
        if (sb.size() != 3) begin
            bad++;
            $display("FAIL throttle writes: got %0d want 3", sb.size());
        end
        drain_sb("throttle");
        pulse_done();
    endtask

    task automatic test_midload_reset();
        job_q = '{5, 11, 12};
        drive_job(1'b0);
        total++;
        if ({start, busy} !== 2'b01) begin
            bad++;
            $display("FAIL midload start/busy: got %b want 01", {start, busy});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        total++;
        if ({start, busy, err, in_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL midload reset outputs start/busy/err/in_ready: got %b want 0001", {start, busy, err, in_ready});
        end
        job_q = '{1, 10'h2AA};
        drive_job(1'b0);
        check_job("after_reset", 3, 0);
        drain_sb("after_reset");
        pulse_done();
    endtask

    task automatic test_zero_len();
        if (CHECK_MODE) begin
            job_q = '{0, 2, 5, 6};
            drive_job(1'b0);
            check_job("zero_len_reject", 5, 1);
            drain_sb("zero_len_reject");
            pulse_done();
        end else begin
            job_q = '{0};
            drive_job(1'b0);
            check_job("zero_len", 2, 0);
            drain_sb("zero_len");
            pulse_done();
            job_q = '{2, 5, 6};
            drive_job(1'b0);
            check_job("after_zero", 4, 0);
            drain_sb("after_zero");
            pulse_done();
        end
    endtask

    task automatic test_max_len();
        job_q.delete();
        job_q.push_back(1023);
        for (int i = 1; i < 1024; i++) job_q.push_back((i * 37 + 5) % 1024);
        drive_job(1'b0);
        check_job("max_len", 1025, 0);
        drain_sb("max_len");
        pulse_done();
        total++;
        if ({start, busy, in_ready} !== 3'b001) begin
            bad++;
            $display("FAIL max_len end start/busy/in_ready: got %b want 001", {start, busy, in_ready});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_throttle();
        test_midload_reset();
        test_zero_len();
        test_max_len();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
